// File: rtl/core_uart_tx.sv
// 8N1 UART transmitter for the core's OUT instruction, with one holding register by default.
// Define CORE_UART_TX_FIFO_EN to buffer pending bytes in a FIFO_DEPTH-entry FIFO instead.
module core_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] OUTDATA,
    input  logic       OUTE,
    output logic       OUT_BUSY,
    output logic       TX_IDLE,
    output logic       TXD
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          idle_q, idle_d;

    logic          accept, pop, pending, pending_d;
    logic [7:0]    head_data;

    assign accept = RST_N && OUTE && !busy_q;
    assign pop    = (state_q == IDLE) && pending;

`ifdef CORE_UART_TX_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [NW-1:0] count_q, count_d;

    assign pending   = (count_q != '0);
    assign head_data = mem_q[rd_ptr_q];
    assign count_d   = count_q + NW'(accept) - NW'(pop);
    assign pending_d = (count_d != '0);
    // A full FIFO stays busy through a pop edge; the slot frees only after it.
    assign busy_d    = (count_d == NW'(FIFO_DEPTH));

    // NOTE: storage has no reset; emptiness is carried by the pointers and count alone.
    always_ff @(posedge CLK) begin
        if (accept) mem_q[wr_ptr_q] <= OUTDATA;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end
`else
    localparam int unused_fifo_depth = FIFO_DEPTH;

    logic [7:0] hold_q;
    logic       hold_valid_q, hold_valid_d;

    assign pending      = hold_valid_q;
    assign head_data    = hold_q;
    assign hold_valid_d = accept || (hold_valid_q && !pop);
    assign pending_d    = hold_valid_d;
    // A byte held while IDLE leaves on the next edge, so a new one may land alongside it.
    assign busy_d       = hold_valid_d && (state_d != IDLE);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            if (accept) hold_q <= OUTDATA;
            hold_valid_q <= hold_valid_d;
        end
    end
`endif

    // NOTE: every next-state signal takes its current value first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        case (state_q)
            IDLE: begin
                if (pending) begin
                    state_d = START;
                    shift_d = head_data;
                    txd_d   = 1'b0;
                    baud_d  = '0;
                end
            end
            START: begin
                if (baud_q == BAUD_MAX) begin
                    state_d   = DATA;
                    baud_d    = '0;
                    bit_idx_d = '0;
                    txd_d     = shift_q[0];
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d    = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        txd_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP: begin
                if (baud_q == BAUD_MAX) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        idle_d = (state_d == IDLE) && !pending_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            idle_q    <= idle_d;
        end
    end

    assign OUT_BUSY = busy_q;
    assign TX_IDLE  = idle_q;
    assign TXD      = txd_q;

endmodule

// File: tb/tb_core_uart_tx.sv
// Directed bench for core_uart_tx at CLKS_PER_BIT=4; FIFO scenarios run when CORE_UART_TX_FIFO_EN is defined.
module tb_core_uart_tx;

    localparam int CPB = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] OUTDATA = 8'h00;
    logic       OUTE = 1'b0;
    logic       OUT_BUSY, TX_IDLE, TXD;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit 0 = start, bits 8:1 = data LSB first, bit 9 = stop
    } vec_t;

    vec_t vecs[6];

    core_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .OUTDATA(OUTDATA), .OUTE(OUTE),
        .OUT_BUSY(OUT_BUSY), .TX_IDLE(TX_IDLE), .TXD(TXD)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Checks TXD on every cycle of a frame, starting at frame cycle 'skip'; ends just after the STOP->IDLE edge.
    task automatic check_frame(input string name, input logic [9:0] frame, input int skip);
        for (int i = skip; i < 10 * CPB; i++) begin
            check($sformatf("%s bit%0d cyc%0d", name, i / CPB, i), {31'd0, TXD}, {31'd0, frame[i / CPB]});
            tick();
        end
    endtask

    // The single high cycle between back-to-back frames.
    task automatic gap(input string name);
        check({name, " gap txd"}, {31'd0, TXD}, 32'd1);
        check({name, " gap tx_idle"}, {31'd0, TX_IDLE}, 32'd0);
        tick();
    endtask

    task automatic watch_quiet(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            if (TXD !== 1'b1 || TX_IDLE !== 1'b1) bad++;
            tick();
        end
        check(name, bad, 0);
    endtask

    initial begin
        vecs[0] = '{8'h55, 10'b1_01010101_0};
        vecs[1] = '{8'h00, 10'b1_00000000_0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0};
        vecs[3] = '{8'hA3, 10'b1_10100011_0};
        vecs[4] = '{8'h01, 10'b1_00000001_0};
        vecs[5] = '{8'h80, 10'b1_10000000_0};

        // Reset with a strobe present: the strobe must leave no trace.
        RST_N = 1'b0; OUTE = 1'b1; OUTDATA = 8'h44;
        tick(); tick();
        check("reset txd", {31'd0, TXD}, 32'd1);
        check("reset busy", {31'd0, OUT_BUSY}, 32'd0);
        check("reset tx_idle", {31'd0, TX_IDLE}, 32'd1);
        RST_N = 1'b1; OUTE = 1'b0;
        watch_quiet("strobe during reset ignored", 8);

        // Single frames from idle: one-cycle latency, exact bit timing, TX_IDLE back 41 cycles after accept.
        for (int v = 0; v < 6; v++) begin
            OUTE = 1'b1; OUTDATA = vecs[v].data;
            tick();
            OUTE = 1'b0;
            check($sformatf("v%0d accept busy", v), {31'd0, OUT_BUSY}, 32'd0);
            check($sformatf("v%0d accept tx_idle", v), {31'd0, TX_IDLE}, 32'd1 - 32'd1);
            check($sformatf("v%0d accept txd", v), {31'd0, TXD}, 32'd1);
            tick();
            check_frame($sformatf("v%0d", v), vecs[v].frame, 0);
            check($sformatf("v%0d end tx_idle", v), {31'd0, TX_IDLE}, 32'd1);
            check($sformatf("v%0d end busy", v), {31'd0, OUT_BUSY}, 32'd0);
            tick(); tick();
        end

`ifdef CORE_UART_TX_FIFO_EN
        // Back-to-back: three strobes on consecutive cycles, none stalled.
        OUTE = 1'b1; OUTDATA = 8'hA3; tick();
        check("b2b busy0", {31'd0, OUT_BUSY}, 32'd0);
        OUTDATA = 8'h0F; tick();
        check("b2b busy1", {31'd0, OUT_BUSY}, 32'd0);
        OUTDATA = 8'hFF; tick();
        check("b2b busy2", {31'd0, OUT_BUSY}, 32'd0);
        OUTE = 1'b0;
        check_frame("b2b A3", 10'b1_10100011_0, 1);
        gap("b2b A3");
        check_frame("b2b 0F", 10'b1_00001111_0, 0);
        gap("b2b 0F");
        check_frame("b2b FF", 10'b1_11111111_0, 0);
        check("b2b end tx_idle", {31'd0, TX_IDLE}, 32'd1);
        tick(); tick();

        // Full/stall: 0x01 shifts out, 0x02..0x05 fill the FIFO, 0x06 retried until accepted.
        OUTE = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            OUTDATA = 8'(k);
            tick();
            check($sformatf("full strobe%0d busy", k), {31'd0, OUT_BUSY}, (k >= 5) ? 32'd1 : 32'd0);
        end
        OUTDATA = 8'h06;
        check_frame("full 01", 10'b1_00000001_0, 4);
        check("full stop->idle busy", {31'd0, OUT_BUSY}, 32'd1);
        check("full stop->idle txd", {31'd0, TXD}, 32'd1);
        tick();
        // OUTE on the pop edge is ignored; the pop leaves DEPTH-1 and busy clears.
        check("full pop busy drops", {31'd0, OUT_BUSY}, 32'd0);
        check("full pop txd start", {31'd0, TXD}, 32'd0);
        tick();
        OUTE = 1'b0;
        check("full retry accepted busy", {31'd0, OUT_BUSY}, 32'd1);
        check_frame("full 02", 10'b1_00000010_0, 1);
        check("full 02 end busy", {31'd0, OUT_BUSY}, 32'd1);
        gap("full 02");
        check("full 03 start busy", {31'd0, OUT_BUSY}, 32'd0);
        check_frame("full 03", 10'b1_00000011_0, 0);
        gap("full 03");
        check_frame("full 04", 10'b1_00000100_0, 0);
        gap("full 04");
        check_frame("full 05", 10'b1_00000101_0, 0);
        gap("full 05");
        check_frame("full 06", 10'b1_00000110_0, 0);
        check("full end tx_idle", {31'd0, TX_IDLE}, 32'd1);
        watch_quiet("full no extra frame", 45);
`else
        // Holding register: 0x11 shifts, 0x22 held, 0x33 dropped.
        OUTE = 1'b1; OUTDATA = 8'h11; tick();
        check("nofifo 11 busy", {31'd0, OUT_BUSY}, 32'd0);
        OUTDATA = 8'h22; tick();
        check("nofifo 22 busy", {31'd0, OUT_BUSY}, 32'd1);
        check("nofifo 22 txd", {31'd0, TXD}, 32'd0);
        OUTDATA = 8'h33; tick();
        OUTE = 1'b0;
        check("nofifo 33 busy", {31'd0, OUT_BUSY}, 32'd1);
        check_frame("nofifo 11", 10'b1_00010001_0, 1);
        gap("nofifo 11");
        check_frame("nofifo 22", 10'b1_00100010_0, 0);
        check("nofifo end tx_idle", {31'd0, TX_IDLE}, 32'd1);
        watch_quiet("nofifo 33 dropped", 45);
`endif

        // Reset during data bit 3 of 0xC0 with a second byte pending.
        OUTE = 1'b1; OUTDATA = 8'hC0; tick();
        OUTDATA = 8'h99; tick();
        OUTE = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        check("midreset pre txd", {31'd0, TXD}, 32'd0);
        check("midreset pre tx_idle", {31'd0, TX_IDLE}, 32'd0);
        RST_N = 1'b0; OUTE = 1'b1; OUTDATA = 8'h44;
        tick();
        check("midreset txd", {31'd0, TXD}, 32'd1);
        check("midreset tx_idle", {31'd0, TX_IDLE}, 32'd1);
        check("midreset busy", {31'd0, OUT_BUSY}, 32'd0);
        tick();
        RST_N = 1'b1; OUTE = 1'b0;
        watch_quiet("midreset no further frame", 50);
        OUTE = 1'b1; OUTDATA = 8'h7E; tick();
        OUTE = 1'b0;
        tick();
        check_frame("post-reset 7E", 10'b1_01111110_0, 0);
        check("post-reset end tx_idle", {31'd0, TX_IDLE}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
